// File: rtl/frame_draw_scheduler.sv
// rtl/frame_draw_scheduler.sv - per-frame sequencer sharing one VGA write port among three draw clients
// Clients run one at a time in index order; only the active client's pixels reach the adapter.
module frame_draw_scheduler #(
  parameter int TIMEOUT = 20000
) (
  input  logic       CLOCK,
  input  logic       RESETN,
  input  logic       FRAME_TICK,
  input  logic [2:0] CLIENT_EN,
  input  logic       CLEAR_FLAGS,
  input  logic [2:0] DONE,
  input  logic [2:0] PLOT_IN,
  input  logic [7:0] X0,
  input  logic [7:0] X1,
  input  logic [7:0] X2,
  input  logic [6:0] Y0,
  input  logic [6:0] Y1,
  input  logic [6:0] Y2,
  input  logic [2:0] C0,
  input  logic [2:0] C1,
  input  logic [2:0] C2,
  output logic [2:0] START,
  output logic [7:0] VGA_X,
  output logic [6:0] VGA_Y,
  output logic [2:0] VGA_COLOUR,
  output logic       VGA_PLOT,
  output logic [1:0] ACTIVE,
  output logic       FRAME_BUSY,
  output logic       FRAME_DONE,
  output logic       OVERRUN,
  output logic       TIMEOUT_ERR
);
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_NEXT, S_FINISH} state_t;

  state_t          state_q, state_d;
  logic [1:0]      active_q, active_d;
  logic [2:0]      en_q, en_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            pending_q, pending_d;
  logic            overrun_q, overrun_d;
  logic            timeout_err_q, timeout_err_d;
  logic [7:0]      vga_x_q, vga_x_d;
  logic [6:0]      vga_y_q, vga_y_d;
  logic [2:0]      vga_colour_q, vga_colour_d;
  logic            vga_plot_q, vga_plot_d;

  logic [3:0]      done_ext, plot_ext;
  logic [1:0]      next_idx;
  logic [7:0]      sel_x;
  logic [6:0]      sel_y;
  logic [2:0]      sel_c;

  // Index 3 stands for "no client" and is never DONE or plotting.
  assign done_ext = {1'b0, DONE};
  assign plot_ext = {1'b0, PLOT_IN};

  // Lowest enabled index at or above 'from'; 3 when none remains.
  function automatic logic [1:0] pick(input logic [2:0] en, input int from);
    pick = 2'd3;
    for (int i = 2; i >= 0; i--) begin
      if (en[i] && i >= from) pick = 2'(i);
    end
  endfunction

  assign next_idx = pick(en_q, int'(active_q) + 1);

  always_ff @(posedge CLOCK or negedge RESETN) begin
    if (!RESETN) begin
      state_q       <= S_IDLE;
      active_q      <= 2'd3;
      en_q          <= '0;
      timer_q       <= '0;
      pending_q     <= 1'b0;
      overrun_q     <= 1'b0;
      timeout_err_q <= 1'b0;
      vga_x_q       <= '0;
      vga_y_q       <= '0;
      vga_colour_q  <= '0;
      vga_plot_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      active_q      <= active_d;
      en_q          <= en_d;
      timer_q       <= timer_d;
      pending_q     <= pending_d;
      overrun_q     <= overrun_d;
      timeout_err_q <= timeout_err_d;
      vga_x_q       <= vga_x_d;
      vga_y_q       <= vga_y_d;
      vga_colour_q  <= vga_colour_d;
      vga_plot_q    <= vga_plot_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    active_d      = active_q;
    en_d          = en_q;
    timer_d       = timer_q;
    pending_d     = pending_q;
    overrun_d     = overrun_q;
    timeout_err_d = timeout_err_q;
    // Clear first so a coincident set below takes priority.
    if (CLEAR_FLAGS) begin
      overrun_d     = 1'b0;
      timeout_err_d = 1'b0;
    end
    if (FRAME_TICK && state_q != S_IDLE) begin
      pending_d = 1'b1;
      if (pending_q) overrun_d = 1'b1;
    end
    case (state_q)
      S_IDLE: begin
        if (FRAME_TICK || pending_q) begin
          en_d      = CLIENT_EN;
          pending_d = 1'b0;
          active_d  = pick(CLIENT_EN, 0);
          state_d   = (CLIENT_EN == 3'b000) ? S_FINISH : S_ISSUE;
        end
      end
      S_ISSUE: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        timer_d = timer_q + 1'b1;
        if (done_ext[active_q]) begin
          state_d = S_NEXT;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          timeout_err_d = 1'b1;
          state_d       = S_NEXT;
        end
      end
      S_NEXT: begin
        active_d = next_idx;
        state_d  = (next_idx == 2'd3) ? S_FINISH : S_ISSUE;
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    case (active_q)
      2'd1:    begin sel_x = X1; sel_y = Y1; sel_c = C1; end
      2'd2:    begin sel_x = X2; sel_y = Y2; sel_c = C2; end
      default: begin sel_x = X0; sel_y = Y0; sel_c = C0; end
    endcase
    vga_x_d      = vga_x_q;
    vga_y_d      = vga_y_q;
    vga_colour_d = vga_colour_q;
    vga_plot_d   = 1'b0;
    if (state_q == S_WAIT) begin
      vga_x_d      = sel_x;
      vga_y_d      = sel_y;
      vga_colour_d = sel_c;
      vga_plot_d   = plot_ext[active_q] && (sel_x <= 8'd159) && (sel_y <= 7'd119);
    end
  end

  always_comb begin
    START       = (state_q == S_ISSUE) ? (3'b001 << active_q) : 3'b000;
    ACTIVE      = active_q;
    FRAME_BUSY  = (state_q != S_IDLE);
    FRAME_DONE  = (state_q == S_FINISH);
    OVERRUN     = overrun_q;
    TIMEOUT_ERR = timeout_err_q;
    VGA_X       = vga_x_q;
    VGA_Y       = vga_y_q;
    VGA_COLOUR  = vga_colour_q;
    VGA_PLOT    = vga_plot_q;
  end
endmodule

// File: tb/tb_frame_draw_scheduler.sv
// tb/tb_frame_draw_scheduler.sv - directed vector table plus multi-cycle sequences for frame_draw_scheduler
module tb_frame_draw_scheduler;
  localparam int TO = 16;

  logic       CLOCK = 1'b0, RESETN = 1'b0, FRAME_TICK = 1'b0, CLEAR_FLAGS = 1'b0;
  logic [2:0] CLIENT_EN = '0, DONE = '0, PLOT_IN = '0;
  logic [7:0] X0 = 8'd5, X1 = 8'd10, X2 = 8'd159;
  logic [6:0] Y0 = 7'd6, Y1 = 7'd20, Y2 = 7'd119;
  logic [2:0] C0 = 3'd1, C1 = 3'd6, C2 = 3'd2;
  logic [2:0] START, VGA_COLOUR;
  logic [7:0] VGA_X;
  logic [6:0] VGA_Y;
  logic       VGA_PLOT, FRAME_BUSY, FRAME_DONE, OVERRUN, TIMEOUT_ERR;
  logic [1:0] ACTIVE;

  frame_draw_scheduler #(.TIMEOUT(TO)) dut (
    .CLOCK(CLOCK), .RESETN(RESETN), .FRAME_TICK(FRAME_TICK), .CLIENT_EN(CLIENT_EN),
    .CLEAR_FLAGS(CLEAR_FLAGS), .DONE(DONE), .PLOT_IN(PLOT_IN),
    .X0(X0), .X1(X1), .X2(X2), .Y0(Y0), .Y1(Y1), .Y2(Y2), .C0(C0), .C1(C1), .C2(C2),
    .START(START), .VGA_X(VGA_X), .VGA_Y(VGA_Y), .VGA_COLOUR(VGA_COLOUR), .VGA_PLOT(VGA_PLOT),
    .ACTIVE(ACTIVE), .FRAME_BUSY(FRAME_BUSY), .FRAME_DONE(FRAME_DONE),
    .OVERRUN(OVERRUN), .TIMEOUT_ERR(TIMEOUT_ERR)
  );

  always #5 CLOCK = ~CLOCK;

  typedef struct {
    logic       tick;
    logic [2:0] en, done, plot;
    logic [7:0] x2;
    logic [27:0] exp;
  } vec_t;

  int vectors = 0, miscompares = 0;
  int st_idx[$], st_cyc[$];
  int fd_cnt, fd_cyc, busy_err, plot_err;
  vec_t tv[13];

  function automatic vec_t mk(logic tick, logic [2:0] en, logic [2:0] done, logic [2:0] plot,
                              logic [7:0] x2, logic [2:0] st, logic [1:0] act, logic busy,
                              logic fd, logic vp, logic [7:0] vx, logic [6:0] vy, logic [2:0] vc);
    vec_t v;
    v.tick = tick; v.en = en; v.done = done; v.plot = plot; v.x2 = x2;
    v.exp  = {st, act, busy, fd, 2'b00, vp, vx, vy, vc};
    return v;
  endfunction

  function automatic logic [27:0] outs();
    return {START, ACTIVE, FRAME_BUSY, FRAME_DONE, OVERRUN, TIMEOUT_ERR, VGA_PLOT, VGA_X, VGA_Y, VGA_COLOUR};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] pk_idx();
    logic [63:0] r = 0;
    foreach (st_idx[i]) r = (r << 4) | 64'(st_idx[i]);
    return r;
  endfunction

  function automatic logic [63:0] pk_cyc();
    logic [63:0] r = 0;
    foreach (st_cyc[i]) r = (r << 8) | 64'(st_cyc[i]);
    return r;
  endfunction

  // Client model: client i raises DONE d_i WAIT cycles after its START (0 = never);
  // client 1 plots (10,20,6) on every cycle of the frame.
  task automatic run_frame(input logic [2:0] en, input bit tick0, input int d0, input int d1,
                           input int d2, input int t1, input int t2, input int clr);
    int  dly[3];
    int  act = 0, wcnt = 0;
    bit  in_w = 0, exp_vp = 0, done_now;
    dly = '{d0, d1, d2};
    st_idx.delete(); st_cyc.delete();
    fd_cnt = 0; fd_cyc = -1; busy_err = 0; plot_err = 0;
    for (int c = 0; c < 400 && fd_cnt == 0; c++) begin
      @(negedge CLOCK);
      if (VGA_PLOT !== exp_vp || (exp_vp && {VGA_X, VGA_Y, VGA_COLOUR} !== {8'd10, 7'd20, 3'd6}))
        plot_err++;
      if (c > 0 && FRAME_BUSY !== 1'b1) busy_err++;
      if (FRAME_DONE === 1'b1) begin fd_cnt++; fd_cyc = c; end
      if (in_w) wcnt++;
      if (START !== 3'b000) begin
        act = (START == 3'b001) ? 0 : (START == 3'b010) ? 1 : (START == 3'b100) ? 2 : 9;
        st_idx.push_back(act); st_cyc.push_back(c);
        if (act > 2) act = 0;
        in_w = 1; wcnt = 0;
      end
      done_now    = in_w && wcnt > 0 && wcnt == dly[act];
      DONE        = done_now ? (3'b001 << act) : 3'b000;
      PLOT_IN     = 3'b010;
      CLIENT_EN   = en;
      FRAME_TICK  = (c == 0 && tick0) || c == t1 || c == t2;
      CLEAR_FLAGS = (c == clr);
      exp_vp      = in_w && wcnt > 0 && act == 1;
      if (in_w && wcnt > 0 && (done_now || wcnt == TO)) in_w = 0;
    end
    DONE = '0; PLOT_IN = '0; FRAME_TICK = 0; CLEAR_FLAGS = 0;
  endtask

  initial begin
    int errs;
    tv[0]  = mk(1, 3'b101, 3'b000, 3'b000, 159, 3'b000, 3, 0, 0, 0,   0,   0, 0);
    tv[1]  = mk(0, 3'b101, 3'b000, 3'b010, 159, 3'b001, 0, 1, 0, 0,   0,   0, 0);
    tv[2]  = mk(0, 3'b101, 3'b000, 3'b010, 159, 3'b000, 0, 1, 0, 0,   0,   0, 0);
    tv[3]  = mk(0, 3'b101, 3'b000, 3'b001, 159, 3'b000, 0, 1, 0, 0,   5,   6, 1);
    tv[4]  = mk(0, 3'b101, 3'b001, 3'b001, 159, 3'b000, 0, 1, 0, 1,   5,   6, 1);
    tv[5]  = mk(0, 3'b101, 3'b000, 3'b001, 159, 3'b000, 0, 1, 0, 1,   5,   6, 1);
    tv[6]  = mk(0, 3'b101, 3'b000, 3'b000, 159, 3'b100, 2, 1, 0, 0,   5,   6, 1);
    tv[7]  = mk(0, 3'b101, 3'b000, 3'b100, 159, 3'b000, 2, 1, 0, 0,   5,   6, 1);
    tv[8]  = mk(0, 3'b101, 3'b010, 3'b100, 160, 3'b000, 2, 1, 0, 1, 159, 119, 2);
    tv[9]  = mk(0, 3'b101, 3'b100, 3'b100, 159, 3'b000, 2, 1, 0, 0, 160, 119, 2);
    tv[10] = mk(0, 3'b101, 3'b000, 3'b000, 159, 3'b000, 2, 1, 0, 1, 159, 119, 2);
    tv[11] = mk(0, 3'b101, 3'b000, 3'b000, 159, 3'b000, 3, 1, 1, 0, 159, 119, 2);
    tv[12] = mk(0, 3'b101, 3'b000, 3'b000, 159, 3'b000, 3, 0, 0, 0, 159, 119, 2);

    repeat (3) @(negedge CLOCK);
    RESETN = 1'b1;

    for (int i = 0; i < 13; i++) begin
      @(negedge CLOCK);
      FRAME_TICK = tv[i].tick; CLIENT_EN = tv[i].en; DONE = tv[i].done;
      PLOT_IN = tv[i].plot; X2 = tv[i].x2;
      #1;
      check($sformatf("vec%0d", i), 64'(outs()), 64'(tv[i].exp));
    end
    FRAME_TICK = 0; DONE = '0; PLOT_IN = '0; X2 = 8'd159;

    run_frame(3'b111, 1, 5, 5, 5, -1, -1, -1);
    check("all_order",  pk_idx(), 64'h012);
    check("all_starts", pk_cyc(), 64'h01080F);
    check("all_fdone",  64'(fd_cyc), 64'd22);
    check("all_busy",   64'(busy_err), 64'd0);
    check("all_pixels", 64'(plot_err), 64'd0);
    check("all_flags",  {62'd0, OVERRUN, TIMEOUT_ERR}, 64'd0);
    @(negedge CLOCK);
    check("all_after", {59'd0, FRAME_DONE, FRAME_BUSY, START == 3'b000, ACTIVE}, {59'd0, 3'b001, 2'd3});

    run_frame(3'b111, 1, 2, 0, 3, -1, -1, -1);
    check("to_order",  pk_idx(), 64'h012);
    check("to_starts", pk_cyc(), 64'h010517);
    check("to_fdone",  64'(fd_cyc), 64'd28);
    check("to_pixels", 64'(plot_err), 64'd0);
    check("to_err",    64'(TIMEOUT_ERR), 64'd1);
    @(negedge CLOCK); CLEAR_FLAGS = 1;
    @(negedge CLOCK); CLEAR_FLAGS = 0;
    check("to_clear",  64'(TIMEOUT_ERR), 64'd0);

    run_frame(3'b001, 1, 16, 0, 0, -1, -1, -1);
    check("edge_fdone", 64'(fd_cyc), 64'd19);
    check("edge_noerr", 64'(TIMEOUT_ERR), 64'd0);

    run_frame(3'b000, 1, 0, 0, 0, -1, -1, -1);
    check("none_starts", 64'(st_idx.size()), 64'd0);
    check("none_fdone",  64'(fd_cyc), 64'd1);

    run_frame(3'b001, 1, 5, 0, 0, 3, 4, 4);
    check("ovr_fdone", 64'(fd_cyc), 64'd8);
    check("ovr_flag",  64'(OVERRUN), 64'd1);
    run_frame(3'b001, 0, 5, 0, 0, -1, -1, -1);
    check("pend_starts", pk_cyc(), 64'h01);
    check("pend_fdone",  64'(fd_cyc), 64'd8);

    @(negedge CLOCK); CLIENT_EN = 3'b001; FRAME_TICK = 1; PLOT_IN = 3'b001;
    @(negedge CLOCK); FRAME_TICK = 0;
    @(negedge CLOCK);
    @(negedge CLOCK);
    check("rst_plot_before", 64'(VGA_PLOT), 64'd1);
    #2 RESETN = 1'b0;
    #1 check("rst_async", 64'(outs()), {36'd0, 3'b000, 2'd3, 23'd0});
    PLOT_IN = '0;
    @(negedge CLOCK); RESETN = 1'b1;
    errs = 0;
    repeat (30) begin
      @(negedge CLOCK);
      if (START !== 3'b000 || FRAME_BUSY !== 1'b0) errs++;
    end
    check("rst_quiet", 64'(errs), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
